plusarg_watchdog: RTL and testbench
===================================

Name: plusarg_watchdog

Overview:
- Run-control watchdog for simulation and bring-up.
- Takes the cycle limit, and optionally a progress-stall limit, as inputs. These are normally driven by plusarg-derived configuration values, such as +max_cycles=N, that are constant after time zero.
- Counts cycles from a start pulse and flags a sticky timeout with a cause code.
- Sits beside the test harness / top-level; its timeout drives the harness finish/fail logic.

Parameters:
- CNT_W, 32: width of the cycle limit and cycle counter.
- STALL_W, 16: width of the stall limit and stall counter.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- max_cycles  input  CNT_W  cycle limit; sampled only on an accepted start; 0 = no cycle limit.
- stall_limit  input  STALL_W  max cycles without progress; sampled on an accepted start; 0 = no stall check.
- start  input  1  pulse; accepted only in IDLE.
- stop  input  1  pulse; RUN -> IDLE, counter frozen.
- clear  input  1  pulse; EXPIRED/IDLE -> IDLE with counters zeroed.
- progress  input  1  heartbeat pulse from the DUT.
- running  output  1  high while in RUN.
- timeout  output  1  sticky, high while in EXPIRED.
- cause  output  2  bit0 = cycle limit hit; bit1 = stall limit hit; valid while timeout = 1.
- cycle_count  output  CNT_W  current/frozen cycle count.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - State = IDLE.
  - running = 0, timeout = 0, cause = 2'b00.
  - cycle_count = 0, stall counter = 0, latched limits = 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, RUN, EXPIRED.
- IDLE:
  - On start: latch max_cycles and stall_limit; cycle_count <= 0; stall counter <= 0; next state RUN.
  - stop is ignored.
  - clear zeroes cycle_count. If start and clear arrive in the same cycle, clear wins and start is dropped.
- RUN:
  - cycle_count increments by 1 every cycle and saturates at all-ones (no wrap).
  - Cycle expiry: if latched limit != 0 and cycle_count == limit-1, next state EXPIRED, cycle_count <= limit, cause[0] <= 1.
  - Example: start sampled at cycle 0 with limit 5 gives running = 1 on cycles 1..5 (count 0..4), then timeout = 1 on cycle 6 with count 5.
  - stop: next state IDLE, cycle_count holds its value.
  - If stop and expiry occur in the same cycle, expiry wins.
  - start and clear are ignored while in RUN.
- EXPIRED:
  - timeout, cause and cycle_count are held.
  - Only clear or reset leaves this state; clear -> IDLE with counters zeroed and cause = 0.
  - start and stop are ignored.
- Changes on max_cycles or stall_limit after an accepted start have no effect until the next start.
- A limit of 1 expires on the first RUN cycle: timeout appears 2 cycles after start.

Optional Feature:
- Macro: PLUSARG_WATCHDOG_STALL_EN.
- Defined:
  - In RUN, the stall counter increments each cycle and saturates. A progress pulse zeroes it in that cycle.
  - If latched stall_limit != 0, progress = 0 and stall counter == stall_limit-1, next state EXPIRED with cause[1] <= 1.
  - If cycle expiry and stall expiry happen in the same cycle, cause = 2'b11.
  - progress in the same cycle as the would-be stall expiry prevents the stall expiry.
- Not defined:
  - The stall counter is not implemented.
  - progress and stall_limit ports remain present but are ignored.
  - cause[1] is constant 0.

Test Plan:
- Cycle expiry: max_cycles=5, start at cycle 0 -> running 1 on cycles 1-5, timeout=1 and cause=2'b01 from cycle 6, cycle_count=5 held for 20 further cycles.
- Stop and freeze: max_cycles=100, start, stop after 10 RUN cycles -> IDLE, running=0, cycle_count=10 frozen; a subsequent start re-zeroes the counter.
- Disabled limit and reset mid-run: max_cycles=0, run 1000 cycles -> no timeout, counter=1000; reset mid-run -> all outputs 0 the next cycle.
- Sticky and clear: from EXPIRED, assert start+stop -> no change; clear+start together -> IDLE, counters 0, start dropped.
- Simultaneous stop and expiry: max_cycles=3, stop on the cycle count=2 -> EXPIRED, cause=2'b01.
- Stall (macro defined): stall_limit=4, max_cycles=0, progress every 3 cycles for 30 cycles -> no timeout; then withhold progress -> timeout with cause=2'b10 exactly 4 cycles after the last progress. With the macro undefined, the same stimulus gives no timeout.

Source files
------------

// File: rtl/plusarg_watchdog.sv
// Run-control watchdog: counts cycles from an accepted start and raises a sticky timeout with a cause code.
// Optional progress-stall detection is compiled in when PLUSARG_WATCHDOG_STALL_EN is defined.
module plusarg_watchdog #(
  parameter int CNT_W   = 32,
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CNT_W-1:0]   max_cycles,
  input  logic [STALL_W-1:0] stall_limit,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               progress,
  output logic               running,
  output logic               timeout,
  output logic [1:0]         cause,
  output logic [CNT_W-1:0]   cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_max_cycles;
  logic [1:0]       r_cause;
  logic             w_cycle_hit;
  logic             w_stall_hit;
  logic             w_expire;
  logic             w_start_ok;
  logic             w_zero;

  // Expiry is detected one count early so the count lands exactly on the limit.
  assign w_cycle_hit = (r_max_cycles != '0) && (r_cycle_count == r_max_cycles - CNT_ONE);
  assign w_expire    = (r_state == S_RUN) && (w_cycle_hit || w_stall_hit);
  assign w_start_ok  = (r_state == S_IDLE) && start && !clear;
  assign w_zero      = ((r_state == S_IDLE) || (r_state == S_EXPIRED)) && clear;

`ifdef PLUSARG_WATCHDOG_STALL_EN
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  logic [STALL_W-1:0] r_stall_limit;
  logic [STALL_W-1:0] r_stall_cnt;

  // A progress pulse in the would-be expiry cycle rescues the run.
  assign w_stall_hit = (r_stall_limit != '0) && !progress &&
                       (r_stall_cnt == r_stall_limit - STALL_ONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_limit <= '0;
      r_stall_cnt   <= '0;
    end else if (w_zero) begin
      r_stall_cnt   <= '0;
    end else if (w_start_ok) begin
      r_stall_limit <= stall_limit;
      r_stall_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      if (progress)
        r_stall_cnt <= '0;
      else if (r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + STALL_ONE;
    end
  end
`else
  logic w_unused_stall;
  assign w_unused_stall = ^{progress, stall_limit};
  assign w_stall_hit    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok)
          w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_expire)
          w_next_state = S_EXPIRED;
        else if (stop)
          w_next_state = S_IDLE;
      end
      S_EXPIRED: begin
        if (clear)
          w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_max_cycles  <= '0;
      r_cause       <= 2'b00;
    end else if (w_zero) begin
      r_cycle_count <= '0;
      r_cause       <= 2'b00;
    end else if (w_start_ok) begin
      r_max_cycles  <= max_cycles;
      r_cycle_count <= '0;
    end else if (r_state == S_RUN) begin
      if (w_expire) begin
        r_cause <= {w_stall_hit, w_cycle_hit};
        if (w_cycle_hit)
          r_cycle_count <= r_max_cycles;
        else if (r_cycle_count != '1)
          r_cycle_count <= r_cycle_count + CNT_ONE;
      end else if (!stop && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + CNT_ONE;
      end
    end
  end

  always_comb begin
    running     = (r_state == S_RUN);
    timeout     = (r_state == S_EXPIRED);
    cause       = r_cause;
    cycle_count = r_cycle_count;
  end

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Scoreboard bench for plusarg_watchdog: a timestamp-based reference model queues expected outputs,
// and a negedge monitor pops and compares them.
module tb_plusarg_watchdog;

  localparam int CNT_W   = 32;
  localparam int STALL_W = 16;
`ifdef PLUSARG_WATCHDOG_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic               clock;
  logic               reset;
  logic [CNT_W-1:0]   max_cycles;
  logic [STALL_W-1:0] stall_limit;
  logic               start, stop, clear, progress;
  logic               running, timeout;
  logic [1:0]         cause;
  logic [CNT_W-1:0]   cycle_count;

  plusarg_watchdog #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .max_cycles  (max_cycles),
    .stall_limit (stall_limit),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .progress    (progress),
    .running     (running),
    .timeout     (timeout),
    .cause       (cause),
    .cycle_count (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned edge_no;
    logic        run;
    logic        to;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: time-stamped view of a run (edge of start, edge of last progress).
  int unsigned t = 0;
  int          m_mode = 0;          // 0 idle, 1 running, 2 expired
  int unsigned m_t0 = 0;
  int unsigned m_lastp = 0;
  logic [31:0] m_lim = 0;
  logic [15:0] m_slim = 0;
  logic [31:0] m_frozen = 0;
  logic [1:0]  m_cause = 0;

  task automatic tick();
    exp_t x;
    bit chit, shit;
    t++;
    if (reset) begin
      m_mode = 0; m_frozen = 0; m_cause = 0; m_lim = 0; m_slim = 0;
    end else begin
      case (m_mode)
        0: begin
          if (clear) m_frozen = 0;
          else if (start) begin
            m_mode = 1; m_t0 = t; m_lastp = t; m_lim = max_cycles; m_slim = stall_limit;
          end
        end
        1: begin
          chit = (m_lim != 0) && ((t - m_t0) == m_lim);
          shit = STALL_EN && (m_slim != 0) && !progress && ((t - m_lastp) == m_slim);
          if (progress) m_lastp = t;
          if (chit || shit) begin
            m_mode = 2; m_cause = {shit, chit}; m_frozen = t - m_t0;
          end else if (stop) begin
            m_mode = 0; m_frozen = t - 1 - m_t0;
          end
        end
        default: begin
          if (clear) begin m_mode = 0; m_frozen = 0; m_cause = 0; end
        end
      endcase
    end
    x.edge_no = t;
    x.run     = (m_mode == 1);
    x.to      = (m_mode == 2);
    x.cause   = m_cause;
    x.cnt     = (m_mode == 1) ? (t - m_t0) : m_frozen;
    @(posedge clock);
    q.push_back(x);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int unsigned edge_no,
                       input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s edge %0d: got %0h expected %0h", name, edge_no, got, want);
    end
  endtask

  exp_t mon_e;
  always @(negedge clock) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("running",     mon_e.edge_no, {31'd0, running},  {31'd0, mon_e.run});
      check("timeout",     mon_e.edge_no, {31'd0, timeout},  {31'd0, mon_e.to});
      check("cause",       mon_e.edge_no, {30'd0, cause},    {30'd0, mon_e.cause});
      check("cycle_count", mon_e.edge_no, cycle_count,       mon_e.cnt);
      $display("edge %0d: run=%0b to=%0b cause=%0b cnt=%0d", mon_e.edge_no,
               running, timeout, cause, cycle_count);
    end
  end

  task automatic pulse_start(); start = 1; tick(); start = 0; endtask
  task automatic pulse_stop();  stop  = 1; tick(); stop  = 0; endtask
  task automatic pulse_clear(); clear = 1; tick(); clear = 0; endtask

  initial begin
    reset = 1; max_cycles = 0; stall_limit = 0;
    start = 0; stop = 0; clear = 0; progress = 0;
    #1;
    ticks(3);
    reset = 0;
    ticks(2);

    // Cycle expiry with limit 5, held for 20 cycles
    max_cycles = 5; pulse_start(); max_cycles = 77;
    ticks(26);
    pulse_clear();

    // Limit of 1
    max_cycles = 1; pulse_start(); ticks(4); pulse_clear();

    // Stop and freeze, then restart re-zeroes
    max_cycles = 100; pulse_start(); ticks(10); pulse_stop(); ticks(5);
    pulse_start(); ticks(4); pulse_stop(); ticks(2);
    stop = 1; ticks(2); stop = 0;

    // Disabled limit, long run, reset mid-run
    max_cycles = 0; pulse_start(); ticks(1000);
    reset = 1; tick(); reset = 0; ticks(3);

    // Sticky expired state, then clear+start together
    max_cycles = 3; pulse_start(); ticks(5);
    start = 1; stop = 1; ticks(3); start = 0; stop = 0;
    clear = 1; start = 1; tick(); clear = 0; start = 0; ticks(3);

    // Stop coinciding with expiry
    max_cycles = 3; pulse_start(); ticks(2); pulse_stop(); ticks(3); pulse_clear();

    // Stall detection with periodic progress, then withheld
    max_cycles = 0; stall_limit = 4; pulse_start();
    for (int i = 0; i < 30; i++) begin
      progress = (i % 3 == 2); tick();
    end
    progress = 0; ticks(8);
    pulse_stop(); pulse_clear(); ticks(2);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 29) == 0);
      clear       = ($urandom_range(0, 39) == 0);
      progress    = ($urandom_range(0, 3) != 0);
      max_cycles  = $urandom_range(0, 25);
      stall_limit = 16'($urandom_range(0, 6));
      tick();
    end
    reset = 0; start = 0; stop = 0; clear = 0; progress = 0;
    ticks(2);

    repeat (3) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
